carry_bypass_adder_checker: RTL and testbench

- Synthesizable response checker for `carry_bypass_adder_base`. It sits at the output end of an adder stimulus stream and complements the exhaustive stimulus generator.
- For each valid vector, it samples operands and DUT outputs, recomputes the golden sum and carry, and counts vectors and mismatches.
- It captures the first failing vector and issues a pass/fail verdict when the stream ends.
- It is used on-chip in BIST wrappers and in self-checking benches in place of `$display` inspection.

---
 rtl/carry_bypass_adder_checker.sv | 110 +++++++++++
 tb/tb_carry_bypass_adder_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/carry_bypass_adder_checker.sv
// carry_bypass_adder_checker: recomputes a+b+cin for each streamed vector, counts mismatches, keeps the first failure and gives a verdict.
module carry_bypass_adder_checker #(
   parameter int BLOCK_LEN = 4,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [BLOCK_LEN-1:0] in_a,
   input  logic [BLOCK_LEN-1:0] in_b,
   input  logic                 in_cin,
   input  logic [BLOCK_LEN-1:0] dut_sum,
   input  logic                 dut_cout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     vec_count,
   output logic [CNT_W-1:0]     err_count,
   output logic                 err_valid,
   output logic [BLOCK_LEN-1:0] err_a,
   output logic [BLOCK_LEN-1:0] err_b,
   output logic                 err_cin,
   output logic [BLOCK_LEN-1:0] err_sum,
   output logic                 err_cout
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   // A full sweep can only be recognised if the vector counter can hold 2**(2*BLOCK_LEN+1).
   localparam bit REACH = CNT_W >= 2 * BLOCK_LEN + 2;
   localparam logic [CNT_W-1:0] TARGET = REACH ? CNT_W'(1) << (2 * BLOCK_LEN + 1) : '0;
   logic [1:0]           r_state;
   logic [BLOCK_LEN-1:0] r_a, r_b, r_sum;
   logic                 r_cin, r_cout, r_v;
   logic [CNT_W-1:0]     r_vec, r_err;
   logic                 r_ev, r_ecin, r_ecout;
   logic [BLOCK_LEN-1:0] r_ea, r_eb, r_esum;
   logic [BLOCK_LEN:0]   w_gold;
   logic                 w_mis, w_start, w_take;
   assign w_gold  = {1'b0, r_a} + {1'b0, r_b} + (BLOCK_LEN + 1)'(r_cin);
   assign w_mis   = r_v && ({r_cout, r_sum} != w_gold);
   assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_take  = in_valid && r_state == S_RUN;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_v     <= 1'b0;
         r_vec   <= '0;
         r_err   <= '0;
         r_ev    <= 1'b0;
         r_ea    <= '0;
         r_eb    <= '0;
         r_ecin  <= 1'b0;
         r_esum  <= '0;
         r_ecout <= 1'b0;
      end else begin
         r_state <= w_start ? S_RUN :
                    (w_take && in_last) ? S_DRAIN :
                    (r_state == S_DRAIN) ? S_DONE : r_state;
         r_v <= w_take;
         if (w_take) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_cin  <= in_cin;
            r_sum  <= dut_sum;
            r_cout <= dut_cout;
         end
         if (w_start) begin
            r_vec   <= '0;
            r_err   <= '0;
            r_ev    <= 1'b0;
            r_ea    <= '0;
            r_eb    <= '0;
            r_ecin  <= 1'b0;
            r_esum  <= '0;
            r_ecout <= 1'b0;
         end else if (r_v) begin
            if (r_vec != '1) r_vec <= r_vec + CNT_W'(1);
            if (w_mis && r_err != '1) r_err <= r_err + CNT_W'(1);
            if (w_mis && !r_ev) begin
               r_ev    <= 1'b1;
               r_ea    <= r_a;
               r_eb    <= r_b;
               r_ecin  <= r_cin;
               r_esum  <= r_sum;
               r_ecout <= r_cout;
            end
         end
      end
   end
   assign busy      = r_state == S_RUN || r_state == S_DRAIN;
   assign done      = r_state == S_DONE;
   assign pass      = done && r_err == '0 && REACH && r_vec == TARGET;
   assign vec_count = r_vec;
   assign err_count = r_err;
   assign err_valid = r_ev;
   assign err_a     = r_ea;
   assign err_b     = r_eb;
   assign err_cin   = r_ecin;
   assign err_sum   = r_esum;
   assign err_cout  = r_ecout;
endmodule

// File: tb/tb_carry_bypass_adder_checker.sv
// tb_carry_bypass_adder_checker: drives vector runs through two checker instances (32-bit and 3-bit counters)
// and scores each run's final results against an arithmetic model.
module tb_carry_bypass_adder_checker;
   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_last, in_cin, dut_cout;
   logic [3:0] in_a, in_b, dut_sum;
   logic        busy, done, pass, err_valid, err_cin, err_cout;
   logic [31:0] vec_count, err_count;
   logic [3:0]  err_a, err_b, err_sum;
   logic        busy3, done3, pass3, err_valid3, err_cin3, err_cout3;
   logic [2:0]  vec_count3, err_count3;
   logic [3:0]  err_a3, err_b3, err_sum3;
   carry_bypass_adder_checker #(.BLOCK_LEN(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(dut_sum), .dut_cout(dut_cout),
      .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
      .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_cin(err_cin),
      .err_sum(err_sum), .err_cout(err_cout));
   carry_bypass_adder_checker #(.BLOCK_LEN(4), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(dut_sum), .dut_cout(dut_cout),
      .busy(busy3), .done(done3), .pass(pass3), .vec_count(vec_count3), .err_count(err_count3),
      .err_valid(err_valid3), .err_a(err_a3), .err_b(err_b3), .err_cin(err_cin3),
      .err_sum(err_sum3), .err_cout(err_cout3));
   always #5 clk = ~clk;
   typedef struct {
      int vec, err, vec3, err3;
      bit ev, ecin, ecout, pass;
      int ea, eb, es;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   int   n_chk = 0, n_fail = 0;
   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask
   // Simulated adder under test: correct except in the injected fault modes.
   function automatic int dut_resp(int mode, int a, int b, int c);
      int s = a + b + c;
      if (mode == 1 && a == 3 && b == 5 && c == 1) s = 8;
      if (mode == 2 && a == 15 && b == 1 && c == 0) s = 0;
      if (mode == 2 && a == 15 && b == 3 && c == 0) s = 2;
      if (mode == 3) s = s ^ 1;
      return s;
   endfunction
   task automatic idle_inputs();
      start = 0; in_valid = 0; in_last = $urandom_range(0, 1);
      in_a = 4'($urandom); in_b = 4'($urandom); in_cin = 1'($urandom);
      {dut_cout, dut_sum} = 5'($urandom);
   endtask
   task automatic begin_run();
      idle_inputs();
      start = 1;
      @(posedge clk); #1;
      idle_inputs();
      cur = '{default: 0};
      chk("busy_after_start", busy, 1);
   endtask
   task automatic send(int a, int b, int c, bit last, bit st, int mode, bit model);
      int r, g;
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
         idle_inputs();
         @(posedge clk); #1;
      end
      r = dut_resp(mode, a, b, c);
      g = a + b + c;
      start = st; in_valid = 1; in_last = last;
      in_a = 4'(a); in_b = 4'(b); in_cin = 1'(c); {dut_cout, dut_sum} = 5'(r);
      @(posedge clk); #1;
      idle_inputs();
      if (model) begin
         cur.vec++;
         if (r != g) begin
            cur.err++;
            if (!cur.ev) begin
               cur.ev = 1; cur.ea = a; cur.eb = b; cur.ecin = 1'(c);
               cur.es = r & 15; cur.ecout = 1'(r >> 4);
            end
         end
      end
   endtask
   task automatic finish_run();
      int t = 0;
      cur.vec3 = cur.vec > 7 ? 7 : cur.vec;
      cur.err3 = cur.err > 7 ? 7 : cur.err;
      cur.pass = cur.err == 0 && cur.vec == 512;
      q.push_back(cur);
      chk("done_not_yet", done, 0);
      @(posedge clk); #1;
      chk("done_after_drain", done, 1);
      chk("busy_in_done", busy, 0);
      while (q.size() != 0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         chk("result_timeout", q.size(), 0);
         q.delete();
      end
   endtask
   task automatic run_sweep(int mode, bit st_mid);
      begin_run();
      for (int i = 0; i < 512; i++)
         send((i >> 5) & 15, (i >> 1) & 15, i & 1, i == 511, st_mid && i == 200, mode, 1);
      finish_run();
   endtask
   task automatic run_rand(int n, int mode);
      begin_run();
      for (int i = 0; i < n; i++)
         send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), i == n - 1, 0, mode, 1);
      finish_run();
   endtask
   initial begin : monitor
      bit pd = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && !pd) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("vec_count", vec_count, e.vec);
               chk("err_count", err_count, e.err);
               chk("err_valid", err_valid, e.ev);
               chk("err_a", err_a, e.ea);
               chk("err_b", err_b, e.eb);
               chk("err_cin", err_cin, e.ecin);
               chk("err_sum", err_sum, e.es);
               chk("err_cout", err_cout, e.ecout);
               chk("pass", pass, e.pass);
               chk("done3", done3, 1);
               chk("vec_count3", vec_count3, e.vec3);
               chk("err_count3", err_count3, e.err3);
               chk("err_valid3", err_valid3, e.ev);
               chk("err_a3", err_a3, e.ea);
               chk("pass3", pass3, 0);
            end
         end
         pd = done;
      end
   end
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end
   initial begin
      rst = 1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_vec", vec_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_err_valid", err_valid, 0);
      chk("rst_err_fields", {err_a, err_b, err_cin, err_sum, err_cout}, 0);
      rst = 0;
      repeat (3) send(1, 2, 0, 1, 0, 0, 0);
      chk("idle_vec_unchanged", vec_count, 0);
      chk("idle_busy", busy, 0);
      run_sweep(0, 0);
      repeat (3) send(4, 4, 1, 1, 0, 0, 0);
      chk("done_vec_unchanged", vec_count, 512);
      chk("done_held", done, 1);
      run_sweep(1, 0);
      run_sweep(2, 0);
      run_rand(10, 0);
      begin_run();
      for (int i = 0; i < 100; i++)
         send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 0, 0, 3, 0);
      rst = 1;
      #1;
      chk("abort_vec", vec_count, 0);
      chk("abort_err", err_count, 0);
      chk("abort_busy", busy, 0);
      chk("abort_err_valid", err_valid, 0);
      @(posedge clk); #1;
      rst = 0;
      run_sweep(0, 1);
      run_rand(20, 3);
      run_rand($urandom_range(30, 60), $urandom_range(0, 3));
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
